// File: rtl/lfsr_prbs_checker.sv
// Self-synchronizing PRBS checker: predicts each received bit from the previous
// LFSR_WIDTH received bits and flags disagreements in a registered error mask.
module lfsr_prbs_checker #(
  parameter int                    LFSR_WIDTH  = 31,
  parameter logic [LFSR_WIDTH-1:0] LFSR_POLY   = 31'h10000001,
  parameter logic [LFSR_WIDTH-1:0] LFSR_INIT   = {LFSR_WIDTH{1'b1}},
  parameter string                 LFSR_CONFIG = "FIBONACCI",
  parameter bit                    REVERSE     = 1'b0,
  parameter bit                    INVERT      = 1'b0,
  parameter int                    DATA_WIDTH  = 8,
  parameter string                 STYLE       = "AUTO"
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_in_valid,
  output logic [DATA_WIDTH-1:0] data_out
);

  localparam bit USE_LOOP = (STYLE == "LOOP");
  // Tap x^j reads the bit received j steps ago, which sits at state bit j-1.
  localparam logic [LFSR_WIDTH-2:0] TAPS = LFSR_POLY[LFSR_WIDTH-1:1];

  if (LFSR_CONFIG != "FIBONACCI" && LFSR_CONFIG != "FIBONACCI_FF") begin : g_bad_config
    $error("lfsr_prbs_checker: unsupported LFSR_CONFIG %s", LFSR_CONFIG);
  end
  if (STYLE != "AUTO" && STYLE != "LOOP" && STYLE != "REDUCTION") begin : g_bad_style
    $error("lfsr_prbs_checker: unsupported STYLE %s", STYLE);
  end
  if (LFSR_WIDTH < 2 || LFSR_WIDTH > 64) begin : g_bad_width
    $error("lfsr_prbs_checker: LFSR_WIDTH %0d out of range 2..64", LFSR_WIDTH);
  end

  logic [LFSR_WIDTH-1:0] state_q;
  logic [LFSR_WIDTH-1:0] state_step;
  logic [DATA_WIDTH-1:0] data_ord;
  logic [DATA_WIDTH-1:0] mask_ord;
  logic [DATA_WIDTH-1:0] mask_out;

  // data_ord[DATA_WIDTH-1] is always the first bit in processing order.
  for (genvar g = 0; g < DATA_WIDTH; g++) begin : g_order
    if (REVERSE) begin : g_lsb_first
      assign data_ord[g]                = data_in[DATA_WIDTH-1-g] ^ INVERT;
      assign mask_out[DATA_WIDTH-1-g]   = mask_ord[g];
    end else begin : g_msb_first
      assign data_ord[g] = data_in[g] ^ INVERT;
      assign mask_out[g] = mask_ord[g];
    end
  end

  function automatic logic feedback(input logic [LFSR_WIDTH-1:0] st);
    logic acc;
    acc = st[LFSR_WIDTH-1];
    if (USE_LOOP) begin
      for (int j = 0; j < LFSR_WIDTH-1; j++) begin
        if (TAPS[j]) acc = acc ^ st[j];
      end
    end else begin
      acc = acc ^ (^(st[LFSR_WIDTH-2:0] & TAPS));
    end
    return acc;
  endfunction

  // The received bit, not the prediction, is shifted in so the checker relocks by itself.
  always_comb begin
    state_step = state_q;
    mask_ord   = '0;
    for (int i = DATA_WIDTH-1; i >= 0; i--) begin
      mask_ord[i] = feedback(state_step) ^ data_ord[i];
      state_step  = {state_step[LFSR_WIDTH-2:0], data_ord[i]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= LFSR_INIT;
      data_out <= '0;
    end else if (data_in_valid) begin
      state_q  <= state_step;
      data_out <= mask_out;
    end
  end

endmodule

// File: tb/tb_lfsr_prbs_checker.sv
// Scoreboard bench for lfsr_prbs_checker: four parameterisations driven in lockstep,
// expected masks from a bit-history reference model, checked by a separate monitor.
module tb_lfsr_prbs_checker;

  localparam int          NL       = 4;
  localparam int          LW[NL]   = '{9, 9, 9, 31};
  localparam int          LD[NL]   = '{8, 8, 8, 32};
  localparam bit          LREV[NL] = '{1'b0, 1'b1, 1'b0, 1'b0};
  localparam bit          LINV[NL] = '{1'b0, 1'b0, 1'b1, 1'b0};
  localparam logic [63:0] LP[NL]   = '{64'h21, 64'h21, 64'h21, 64'h10000001};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vin = 1'b0;
  logic [7:0]  din0, din1, din2, dout0, dout1, dout2;
  logic [31:0] din3, dout3;

  int tests = 0;
  int fails = 0;
  int errcnt = 0;

  logic [31:0] exp_q[NL][$];
  logic [31:0] last_exp[NL];
  // hb[l] = model history of lane l, hb[l+NL] = stream generator of lane l;
  // element a holds the bit seen a+1 steps ago.
  bit hb[2*NL][64];

  always #5 clk = ~clk;

  lfsr_prbs_checker #(.LFSR_WIDTH(9), .LFSR_POLY(9'h021), .LFSR_INIT(9'h1FF),
    .DATA_WIDTH(8)) u0 (.clk(clk), .rst_n(rst_n), .data_in(din0),
    .data_in_valid(vin), .data_out(dout0));
  lfsr_prbs_checker #(.LFSR_WIDTH(9), .LFSR_POLY(9'h021), .LFSR_INIT(9'h1FF),
    .REVERSE(1'b1), .DATA_WIDTH(8), .STYLE("REDUCTION")) u1 (.clk(clk), .rst_n(rst_n),
    .data_in(din1), .data_in_valid(vin), .data_out(dout1));
  lfsr_prbs_checker #(.LFSR_WIDTH(9), .LFSR_POLY(9'h021), .LFSR_INIT(9'h1FF),
    .INVERT(1'b1), .DATA_WIDTH(8), .LFSR_CONFIG("FIBONACCI_FF")) u2 (.clk(clk),
    .rst_n(rst_n), .data_in(din2), .data_in_valid(vin), .data_out(dout2));
  lfsr_prbs_checker #(.LFSR_WIDTH(31), .LFSR_POLY(31'h10000001),
    .DATA_WIDTH(32), .STYLE("LOOP")) u3 (.clk(clk), .rst_n(rst_n), .data_in(din3),
    .data_in_valid(vin), .data_out(dout3));

  function automatic logic [31:0] get_dout(input int l);
    case (l)
      0: return {24'd0, dout0};
      1: return {24'd0, dout1};
      2: return {24'd0, dout2};
      default: return dout3;
    endcase
  endfunction

  task automatic set_din(input int l, input logic [31:0] w);
    case (l)
      0: din0 = w[7:0];
      1: din1 = w[7:0];
      2: din2 = w[7:0];
      default: din3 = w;
    endcase
  endtask

  task automatic check(input string nm, input int l, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s lane %0d: got %h expected %h at %0t", nm, l, act, exp, $time);
    end
  endtask

  // Next bit of the recurrence b[n] = b[n-W] ^ XOR of b[n-j] for each tap x^j.
  function automatic bit predict(input int idx, input int l);
    bit p;
    p = hb[idx][LW[l]-1];
    for (int j = 1; j < LW[l]; j++) if (LP[l][j]) p ^= hb[idx][j-1];
    return p;
  endfunction

  function automatic void shift_in(input int idx, input bit b);
    for (int a = 63; a > 0; a--) hb[idx][a] = hb[idx][a-1];
    hb[idx][0] = b;
  endfunction

  function automatic void seed(input int idx, input int l, input bit rnd);
    for (int a = 0; a < 64; a++) hb[idx][a] = (a < LW[l]) ? (rnd ? 1'($urandom) : 1'b1) : 1'b0;
    if (rnd) hb[idx][0] = 1'b1;
  endfunction

  function automatic logic [31:0] gen_word(input int l);
    logic [31:0] w = '0;
    for (int i = 0; i < LD[l]; i++) begin
      bit b = predict(l + NL, l);
      shift_in(l + NL, b);
      w[LREV[l] ? i : LD[l]-1-i] = b ^ LINV[l];
    end
    return w;
  endfunction

  function automatic logic [31:0] model_word(input int l, input logic [31:0] w);
    logic [31:0] m = '0;
    for (int i = 0; i < LD[l]; i++) begin
      int pos = LREV[l] ? i : LD[l]-1-i;
      bit d = w[pos] ^ LINV[l];
      m[pos] = predict(l, l) ^ d;
      shift_in(l, d);
    end
    return m;
  endfunction

  function automatic void model_reset();
    for (int l = 0; l < NL; l++) begin
      seed(l, l, 1'b0);
      last_exp[l] = '0;
    end
  endfunction

  // mode 0: normal, 1: flip lane-0 bit k, 2: lane-0 sends 0x00 (expected mask 0x07)
  task automatic drive(input bit v, input int mode, input int k);
    logic [31:0] w, e;
    @(negedge clk);
    vin = v;
    for (int l = 0; l < NL; l++) begin
      if (v) begin
        w = gen_word(l);
        if (l == 0 && mode == 1) w[k] = ~w[k];
        if (l == 0 && mode == 2) w = '0;
        e = model_word(l, w);
        if (l == 0 && mode == 2) e = 32'h07;
        exp_q[l].push_back(e);
      end else begin
        w = $urandom;
      end
      set_din(l, w);
    end
  endtask

  task automatic hard_reset();
    @(negedge clk);
    rst_n = 1'b0;
    vin = 1'b0;
    model_reset();
    for (int l = 0; l < NL; l++) seed(l + NL, l, 1'b0);
    repeat (2) @(negedge clk);
    for (int l = 0; l < NL; l++) check("reset_out", l, get_dout(l), 32'h0);
    rst_n = 1'b1;
  endtask

  task automatic async_pulse();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    vin = 1'b0;
    #1;
    for (int l = 0; l < NL; l++) check("async_reset_out", l, get_dout(l), 32'h0);
    model_reset();
    #2;
    rst_n = 1'b1;
  endtask

  initial begin : monitor
    bit v_s, r_s;
    logic [31:0] e;
    forever begin
      @(posedge clk);
      v_s = vin;
      r_s = rst_n;
      #1;
      if (r_s && rst_n) begin
        for (int l = 0; l < NL; l++) begin
          if (v_s) begin
            if (exp_q[l].size() == 0) begin
              tests++;
              fails++;
              $display("FAIL scoreboard_underflow lane %0d: got output, expected none", l);
            end else begin
              e = exp_q[l].pop_front();
              check("mask", l, get_dout(l), e);
              last_exp[l] = e;
              if (l == 0) errcnt += $countones(dout0);
            end
          end else begin
            check("hold", l, get_dout(l), last_exp[l]);
          end
        end
      end
    end
  end

  initial begin : stimulus
    din0 = '0; din1 = '0; din2 = '0; din3 = '0;
    model_reset();
    for (int l = 0; l < NL; l++) seed(l + NL, l, 1'b0);
    repeat (2) @(negedge clk);
    for (int l = 0; l < NL; l++) check("reset_out", l, get_dout(l), 32'h0);
    rst_n = 1'b1;

    drive(1'b1, 2, 0);
    drive(1'b0, 0, 0);
    check("state_wrong_start", 0, 32'(u0.state_q), 32'h100);

    hard_reset();
    repeat (30) drive(1'b1, 0, 0);
    repeat (60) drive($urandom_range(0, 9) < 6, 0, 0);

    for (int l = 0; l < NL; l++) seed(l + NL, l, 1'b1);
    repeat (20) drive(1'b1, 0, 0);

    repeat (4) begin
      drive(1'b0, 0, 0);
      errcnt = 0;
      drive(1'b1, 1, $urandom_range(0, 7));
      repeat (3) drive(1'b1, 0, 0);
      drive(1'b0, 0, 0);
      drive(1'b0, 0, 0);
      check("inject_err_bits", 0, 32'(errcnt), 32'd3);
      repeat (5) drive(1'b1, 0, 0);
    end

    repeat (2) begin
      repeat (10) drive(1'b1, 0, 0);
      async_pulse();
      repeat (15) drive($urandom_range(0, 3) != 0, 0, 0);
    end

    hard_reset();
    repeat (20) drive($urandom_range(0, 4) != 0, 0, 0);
    drive(1'b0, 0, 0);
    drive(1'b0, 0, 0);
    for (int l = 0; l < NL; l++) check("queue_drained", l, 32'(exp_q[l].size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lfsr_prbs_checker.md
# lfsr_prbs_checker

Self-synchronizing PRBS checker. It compares an incoming parallel pseudo-random bit stream against the sequence predicted from the bits already received. The block sits at the receive end of a link or BIST path, behind the deserializer. For each valid input word it outputs a registered error mask of DATA_WIDTH bits: 1 marks a bit that disagrees with the LFSR prediction. It locks to any phase of the sequence once LFSR_WIDTH consecutive error-free bits have been received; no seeding handshake exists.

## Interface
- LFSR_WIDTH, 31: LFSR length in bits (2..64).
- LFSR_POLY, 31'h10000001: feedback polynomial. Bit j (j≥1) set means tap x^j. The x^LFSR_WIDTH term is implicit. PRBS9 is 9'h021, i.e. x^9+x^5+1.
- LFSR_INIT, all ones: reset value of the state register.
- LFSR_CONFIG, "FIBONACCI": "FIBONACCI" and "FIBONACCI_FF" are both legal and behave identically (Fibonacci, feed-forward). Any other value is an elaboration error.
- REVERSE, 0: 0 = process data_in MSB first; 1 = LSB first, with data_out bit-mapped the same way.
- INVERT, 0: 1 = invert data_in before checking.
- DATA_WIDTH, 8: bits per input word.
- STYLE, "AUTO": "AUTO", "LOOP" or "REDUCTION". Selects the implementation style of the XOR network only; it has no functional effect.
- clk  in  1  clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- data_in  in  DATA_WIDTH  received PRBS word.
- data_in_valid  in  1  qualifies data_in for one cycle.
- data_out  out  DATA_WIDTH  registered error mask.

## Operation
- State: an LFSR_WIDTH-bit register s and a DATA_WIDTH-bit output register.
- Each valid word is processed as DATA_WIDTH sequential bit steps, unrolled combinationally within one cycle.
- Bit order: REVERSE=0 walks from bit DATA_WIDTH-1 down to 0; REVERSE=1 walks from bit 0 up.
- Per bit d, where d is data_in, inverted if INVERT=1:
  - Prediction: fb = s[W-1] XOR (XOR over j=1..W-1 with LFSR_POLY[j]=1 of s[j-1]).
  - Error bit: e = fb XOR d, written to the same bit position of data_out.
  - Shift: s <= {s[W-2:0], d}. The received bit is shifted in, not fb; this is what makes the checker self-synchronizing.
- Single-bit error propagation: one flipped input bit at position k yields one error bit at k plus one error bit per tap lag. For PRBS9 the errors fall at k, k+5 and k+9.
- Only data is checked. There is no error counter and no lock flag.

## Timing
- Reset (rst_n=0, asynchronous): s = LFSR_INIT and data_out = 0, held while rst_n is low. Release is synchronous to clk.
- Latency is 1 cycle: the mask for the word accepted at edge N appears on data_out right after edge N.
- data_in_valid=0: s and data_out both hold their values, with no advance.
- Back-to-back valid words run at full rate, one word per cycle.
- Reset asserted mid-stream discards history. The next word is checked against LFSR_INIT, so a few spurious error bits may follow until LFSR_WIDTH good bits have been shifted in.

## Test plan
- PRBS9, reset then valid words: send 0x07, then continuing PRBS9 words generated from state 0x1FF MSB-first. Required: data_out = 0x00 for every word.
- Wrong start from reset: send 0x00 after reset. Required: data_out = 0x07, and state = 0x100.
- Arbitrary-phase lock: start the PRBS stream at a random offset. Required: nonzero masks only on the first 2 words, then 0x00 indefinitely.
- Injected error: flip one bit at stream position k. Required: exactly three error bits, at k, k+5 and k+9, then 0x00 again.
- Valid gaps and reset: insert random data_in_valid=0 cycles, with junk on data_in during the gaps. Required: data_out holds and checking stays error-free. Pulse rst_n low asynchronously between clock edges. Required: data_out=0 immediately.
- Parameter sweep: REVERSE=1 with a bit-reversed stream, INVERT=1 with a complemented stream, and PRBS31 (W=31, poly 31'h10000001) with DATA_WIDTH=32. Required: all-zero masks after lock.
